lv_mode_ctrl: RTL and testbench
===============================

# lv_mode_ctrl

Low-voltage-side mode controller: the producer of the 8-bit `reg_mode_str` mode word that every LV block decodes. It sequences power-up through eFuse load, then arbitrates the operating mode (CFG, NORMAL, BIST, FSISO, RESET) from SPI-decoded requests and fault triggers. It drives the registered one-hot mode bits plus the `efuse_done`, `adc1_en` and `adc2_en` qualifiers. It sits between the SPI register decoder / fault aggregator and all mode consumers in `lv_top`.

## Interface
- `EFUSE_TMO`, default 1024: cycles allowed for the eFuse load handshake before failing.
- `BIST_TMO`, default 4096: cycles allowed in BIST before a forced abort.
- `clk`  in  1  block clock.
- `rst`  in  1  synchronous, active-high reset.
- `i_reset_req`  in  1  soft-reset request, level, sampled each cycle.
- `i_fsiso_trig`  in  1  fault trigger into fail-safe isolation, level.
- `i_fsiso_clr`  in  1  FSISO exit request, level.
- `i_bist_req`  in  1  BIST entry request, level.
- `i_bist_done`  in  1  BIST engine finished, 1-cycle pulse.
- `i_cfg_req`  in  1  CFG entry request, level.
- `i_normal_req`  in  1  NORMAL entry request, level.
- `i_adc1_req`, `i_adc2_req`  in  1 each  ADC enable requests.
- `o_efuse_load_req`  out  1  eFuse load request, level.
- `i_efuse_load_done`  in  1  eFuse load acknowledge, 1-cycle pulse.
- `o_reg_mode`  out  8  mode word. Bit assignment: [7] efuse_done, [6] adc2_en, [5] adc1_en, [4] fsiso_en, [3] bist_en, [2] cfg_en, [1] normal_en, [0] reset_en.
- `o_mode_chg`  out  1  1-cycle pulse whenever bits [4:0] change.
- `o_efuse_err`  out  1  sticky: eFuse load timed out.
- `o_bist_err`  out  1  sticky: BIST timed out.

## Operation
- States: RESET, CFG, NORMAL, BIST, FSISO. Bits [4:0] of `o_reg_mode` are exactly one-hot in every state.
- One shared 16-bit down-counter. It is loaded on entry to RESET (`EFUSE_TMO-1`) and on entry to BIST (`BIST_TMO-1`), and it holds at 0.

**RESET**
- `o_efuse_load_req`=1 while waiting.
- On `i_efuse_load_done`: set `efuse_done`, drop the request, go to CFG.
- Counter at 0 with no done: set `o_efuse_err`, go to FSISO, `efuse_done` stays 0.
- All other requests are ignored in RESET.

**Other states**
- Request priority, highest first: `i_reset_req` > `i_fsiso_trig` > state-specific requests.
- `i_reset_req` → RESET. This clears `efuse_done` and reloads the counter. The sticky errors are kept.
- `i_fsiso_trig` → FSISO (from CFG, NORMAL, BIST).
- CFG: `i_bist_req` → BIST; otherwise `i_normal_req` → NORMAL. `i_cfg_req` is ignored.
- NORMAL: `i_cfg_req` → CFG. `i_bist_req` and `i_normal_req` are ignored.
- BIST: `i_bist_done` → CFG. Counter at 0 → set `o_bist_err`, go to FSISO.
- FSISO: `i_fsiso_clr` && !`i_fsiso_trig` → CFG. Exit is blocked while the trigger is held.

**ADC enables and status**
- `adc1_en` = registered `i_adc1_req` gated by (next state ∈ {CFG, NORMAL}); `adc2_en` likewise. Both are forced to 0 in RESET, BIST and FSISO.
- `o_mode_chg` is asserted the cycle the new one-hot value first appears on `o_reg_mode`.
- `o_efuse_err` and `o_bist_err` clear only on `rst`.

## Timing
- All outputs are registered; there is no combinational input-to-output path.
- Latency: a request sampled high at edge N gives the new `o_reg_mode` after edge N.
  - `o_mode_chg` is high during the cycle following edge N only.
- Reset values: `o_reg_mode`=8'h01, `o_efuse_load_req`=0, `o_mode_chg`=0, `o_efuse_err`=0, `o_bist_err`=0, counter=`EFUSE_TMO-1`.
- First cycle after `rst` deasserts: `o_efuse_load_req`=1.
- `i_efuse_load_done` at edge N: `o_reg_mode`=8'h84 (efuse_done + cfg_en) after edge N, and `o_efuse_load_req`=0 in the same cycle.
- eFuse timeout: with no done pulse, FSISO (8'h10) appears `EFUSE_TMO` cycles after RESET entry.
- `rst` asserted mid-operation: state returns to RESET and all outputs take their reset values at the next edge, overriding any concurrent request.
- `i_efuse_load_done` outside RESET is ignored. `i_bist_done` outside BIST is ignored.

## Test plan
- Power-up: release `rst`, pulse `i_efuse_load_done` 5 cycles later → `o_reg_mode` goes 8'h01 → 8'h84, one `o_mode_chg` pulse, request drops.
- eFuse timeout with `EFUSE_TMO`=16: never acknowledge → at cycle 16 `o_reg_mode`=8'h10, `o_efuse_err`=1; assert `i_fsiso_clr` → 8'h04 (efuse_done=0).
- CFG → NORMAL with `i_adc1_req`=1 → 8'hA2. Then `i_fsiso_trig` and `i_cfg_req` in the same cycle → 8'h90 (FSISO wins, adc_en cleared).
- BIST: from CFG assert `i_bist_req` → 8'h88; pulse `i_bist_done` → 8'h84. Repeat with `BIST_TMO`=32 and no done → 8'h90 after 32 cycles, `o_bist_err`=1.
- FSISO exit blocked: hold `i_fsiso_trig` and `i_fsiso_clr` together → stays 8'h90; drop trigger → 8'h84 next cycle.
- Soft reset from NORMAL via `i_reset_req` → 8'h01, `o_efuse_load_req`=1, errors retained. Assert `rst` mid-BIST → 8'h01 and errors cleared.

Source files
------------

// File: rtl/lv_mode_ctrl.sv
// LV-side mode controller: sequences the eFuse load after reset and then arbitrates
// the one-hot operating mode word (RESET/CFG/NORMAL/BIST/FSISO) plus the ADC qualifiers.
module lv_mode_ctrl #(
    parameter int EFUSE_TMO = 1024,
    parameter int BIST_TMO  = 4096
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_reset_req,
    input  logic       i_fsiso_trig,
    input  logic       i_fsiso_clr,
    input  logic       i_bist_req,
    input  logic       i_bist_done,
    input  logic       i_cfg_req,
    input  logic       i_normal_req,
    input  logic       i_adc1_req,
    input  logic       i_adc2_req,
    output logic       o_efuse_load_req,
    input  logic       i_efuse_load_done,
    output logic [7:0] o_reg_mode,
    output logic       o_mode_chg,
    output logic       o_efuse_err,
    output logic       o_bist_err
);

    localparam logic [2:0] ST_RESET  = 3'd0;
    localparam logic [2:0] ST_CFG    = 3'd1;
    localparam logic [2:0] ST_NORMAL = 3'd2;
    localparam logic [2:0] ST_BIST   = 3'd3;
    localparam logic [2:0] ST_FSISO  = 3'd4;

    localparam logic [15:0] EFUSE_LOAD = 16'(EFUSE_TMO - 1);
    localparam logic [15:0] BIST_LOAD  = 16'(BIST_TMO - 1);

    // Bit position follows the mode word: [4] fsiso .. [0] reset.
    function automatic logic [4:0] f_onehot(input logic [2:0] st);
        logic [4:0] oh;
        case (st)
            ST_RESET:  oh = 5'b00001;
            ST_NORMAL: oh = 5'b00010;
            ST_CFG:    oh = 5'b00100;
            ST_BIST:   oh = 5'b01000;
            ST_FSISO:  oh = 5'b10000;
            default:   oh = 5'b00001;
        endcase
        return oh;
    endfunction

    logic [2:0]  r_state;
    logic [15:0] r_cnt;
    logic [7:0]  r_mode;
    logic        r_load_req;
    logic        r_mode_chg;
    logic        r_efuse_err;
    logic        r_bist_err;

    logic [2:0]  w_next_state;
    logic [15:0] w_cnt_next;
    logic        w_efuse_done_next;
    logic        w_efuse_err_set;
    logic        w_bist_err_set;
    logic        w_adc_ok;
    logic [7:0]  w_mode_next;

    // Next-state arbitration and shared timeout counter update.
    always_comb begin
        w_next_state      = r_state;
        w_efuse_done_next = r_mode[7];
        w_efuse_err_set   = 1'b0;
        w_bist_err_set    = 1'b0;
        if (r_cnt != 16'd0) begin
            w_cnt_next = r_cnt - 16'd1;
        end else begin
            w_cnt_next = 16'd0;
        end

        case (r_state)
            ST_RESET: begin
                if (i_efuse_load_done) begin
                    w_next_state      = ST_CFG;
                    w_efuse_done_next = 1'b1;
                end else if (r_cnt == 16'd0) begin
                    w_next_state    = ST_FSISO;
                    w_efuse_err_set = 1'b1;
                end else begin
                    w_next_state = ST_RESET;
                end
            end
            default: begin
                if (i_reset_req) begin
                    w_next_state      = ST_RESET;
                    w_efuse_done_next = 1'b0;
                    w_cnt_next        = EFUSE_LOAD;
                end else if (i_fsiso_trig) begin
                    w_next_state = ST_FSISO;
                end else begin
                    case (r_state)
                        ST_CFG: begin
                            if (i_bist_req) begin
                                w_next_state = ST_BIST;
                                w_cnt_next   = BIST_LOAD;
                            end else if (i_normal_req) begin
                                w_next_state = ST_NORMAL;
                            end else begin
                                w_next_state = ST_CFG;
                            end
                        end
                        ST_NORMAL: begin
                            if (i_cfg_req) begin
                                w_next_state = ST_CFG;
                            end else begin
                                w_next_state = ST_NORMAL;
                            end
                        end
                        ST_BIST: begin
                            if (i_bist_done) begin
                                w_next_state = ST_CFG;
                            end else if (r_cnt == 16'd0) begin
                                w_next_state   = ST_FSISO;
                                w_bist_err_set = 1'b1;
                            end else begin
                                w_next_state = ST_BIST;
                            end
                        end
                        ST_FSISO: begin
                            if (i_fsiso_clr) begin
                                w_next_state = ST_CFG;
                            end else begin
                                w_next_state = ST_FSISO;
                            end
                        end
                        default: begin
                            // Unreachable encodings recover through a full eFuse reload.
                            w_next_state      = ST_RESET;
                            w_efuse_done_next = 1'b0;
                            w_cnt_next        = EFUSE_LOAD;
                        end
                    endcase
                end
            end
        endcase

        w_adc_ok    = (w_next_state == ST_CFG) || (w_next_state == ST_NORMAL);
        w_mode_next = {w_efuse_done_next, i_adc2_req & w_adc_ok, i_adc1_req & w_adc_ok,
                       f_onehot(w_next_state)};
    end

    // State, counter and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_RESET;
            r_cnt       <= EFUSE_LOAD;
            r_mode      <= 8'h01;
            r_load_req  <= 1'b0;
            r_mode_chg  <= 1'b0;
            r_efuse_err <= 1'b0;
            r_bist_err  <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_cnt       <= w_cnt_next;
            r_mode      <= w_mode_next;
            r_load_req  <= (w_next_state == ST_RESET);
            r_mode_chg  <= (w_mode_next[4:0] != r_mode[4:0]);
            r_efuse_err <= r_efuse_err | w_efuse_err_set;
            r_bist_err  <= r_bist_err | w_bist_err_set;
        end
    end

    assign o_reg_mode       = r_mode;
    assign o_efuse_load_req = r_load_req;
    assign o_mode_chg       = r_mode_chg;
    assign o_efuse_err      = r_efuse_err;
    assign o_bist_err       = r_bist_err;

endmodule

// File: tb/tb_lv_mode_ctrl.sv
// Bench for lv_mode_ctrl: directed power-up/mode scenarios with literal expectations,
// then randomized requests checked every cycle against a deadline-based behavioural model.
module tb_lv_mode_ctrl;

    localparam int ETMO = 16;
    localparam int BTMO = 32;

    localparam int M_RESET  = 0;
    localparam int M_NORMAL = 1;
    localparam int M_CFG    = 2;
    localparam int M_BIST   = 3;
    localparam int M_FSISO  = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       i_reset_req, i_fsiso_trig, i_fsiso_clr, i_bist_req, i_bist_done;
    logic       i_cfg_req, i_normal_req, i_adc1_req, i_adc2_req, i_efuse_load_done;
    logic       o_efuse_load_req, o_mode_chg, o_efuse_err, o_bist_err;
    logic [7:0] o_reg_mode;

    int checks   = 0;
    int failures = 0;

    lv_mode_ctrl #(.EFUSE_TMO(ETMO), .BIST_TMO(BTMO)) dut (
        .clk               (clk),
        .rst               (rst),
        .i_reset_req       (i_reset_req),
        .i_fsiso_trig      (i_fsiso_trig),
        .i_fsiso_clr       (i_fsiso_clr),
        .i_bist_req        (i_bist_req),
        .i_bist_done       (i_bist_done),
        .i_cfg_req         (i_cfg_req),
        .i_normal_req      (i_normal_req),
        .i_adc1_req        (i_adc1_req),
        .i_adc2_req        (i_adc2_req),
        .o_efuse_load_req  (o_efuse_load_req),
        .i_efuse_load_done (i_efuse_load_done),
        .o_reg_mode        (o_reg_mode),
        .o_mode_chg        (o_mode_chg),
        .o_efuse_err       (o_efuse_err),
        .o_bist_err        (o_bist_err)
    );

    always #5 clk = ~clk;

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b expected=%b t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_st, m_deadline, ecnt;
    bit m_edone, m_eerr, m_berr, m_adc1, m_adc2, m_lreq, m_chg, m_valid;

    initial begin
        ecnt    = 0;
        m_valid = 1'b0;
    end

    function automatic logic [7:0] exp_word(input int st, input bit ed, input bit a1, input bit a2);
        int w;
        w = 1 << st;
        if (ed) w += 128;
        if (a2) w += 64;
        if (a1) w += 32;
        return 8'(w);
    endfunction

    always @(posedge clk) begin : model
        int ns, dl;
        bit ed, ee, be, opr;
        if (rst) begin
            m_st       <= M_RESET;
            m_edone    <= 1'b0;
            m_eerr     <= 1'b0;
            m_berr     <= 1'b0;
            m_adc1     <= 1'b0;
            m_adc2     <= 1'b0;
            m_lreq     <= 1'b0;
            m_chg      <= 1'b0;
            m_deadline <= ecnt + ETMO;
            m_valid    <= 1'b1;
        end else if (m_valid) begin
            ns = m_st; dl = m_deadline; ed = m_edone; ee = 1'b0; be = 1'b0;
            if (m_st == M_RESET) begin
                if (i_efuse_load_done) begin
                    ns = M_CFG; ed = 1'b1;
                end else if (ecnt >= m_deadline) begin
                    ns = M_FSISO; ee = 1'b1;
                end
            end else if (i_reset_req) begin
                ns = M_RESET; ed = 1'b0; dl = ecnt + ETMO;
            end else if (i_fsiso_trig) begin
                ns = M_FSISO;
            end else if (m_st == M_CFG) begin
                if (i_bist_req) begin
                    ns = M_BIST; dl = ecnt + BTMO;
                end else if (i_normal_req) begin
                    ns = M_NORMAL;
                end
            end else if (m_st == M_NORMAL) begin
                if (i_cfg_req) ns = M_CFG;
            end else if (m_st == M_BIST) begin
                if (i_bist_done) begin
                    ns = M_CFG;
                end else if (ecnt >= m_deadline) begin
                    ns = M_FSISO; be = 1'b1;
                end
            end else begin
                if (i_fsiso_clr) ns = M_CFG;
            end
            opr = (ns == M_CFG) || (ns == M_NORMAL);
            m_st       <= ns;
            m_deadline <= dl;
            m_edone    <= ed;
            m_eerr     <= m_eerr | ee;
            m_berr     <= m_berr | be;
            m_adc1     <= i_adc1_req & opr;
            m_adc2     <= i_adc2_req & opr;
            m_lreq     <= (ns == M_RESET);
            m_chg      <= (ns != m_st);
        end
        ecnt <= ecnt + 1;
    end

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (m_valid) begin
            chk8("mdl_reg_mode", o_reg_mode, exp_word(m_st, m_edone, m_adc1, m_adc2));
            chk1("mdl_load_req", o_efuse_load_req, m_lreq);
            chk1("mdl_mode_chg", o_mode_chg, m_chg);
            chk1("mdl_efuse_err", o_efuse_err, m_eerr);
            chk1("mdl_bist_err", o_bist_err, m_berr);
        end
    end

    // ---------------- stimulus ----------------
    task automatic clear_inputs();
        i_reset_req = 1'b0; i_fsiso_trig = 1'b0; i_fsiso_clr = 1'b0; i_bist_req = 1'b0;
        i_bist_done = 1'b0; i_cfg_req = 1'b0; i_normal_req = 1'b0; i_adc1_req = 1'b0;
        i_adc2_req = 1'b0; i_efuse_load_done = 1'b0;
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic pct(input int p);
        return ($urandom_range(0, 99) < p) ? 1'b1 : 1'b0;
    endfunction

    initial begin
        clear_inputs();
        rst = 1'b1;
        tick(3);
        chk8("rst_mode", o_reg_mode, 8'h01);
        chk1("rst_load_req", o_efuse_load_req, 1'b0);
        chk1("rst_chg", o_mode_chg, 1'b0);
        chk1("rst_eerr", o_efuse_err, 1'b0);
        rst = 1'b0;
        tick(1);
        chk1("pwr_load_req_up", o_efuse_load_req, 1'b1);
        tick(4);
        i_efuse_load_done = 1'b1; tick(1); i_efuse_load_done = 1'b0;
        chk8("pwr_mode_84", o_reg_mode, 8'h84);
        chk1("pwr_chg", o_mode_chg, 1'b1);
        chk1("pwr_load_req_drop", o_efuse_load_req, 1'b0);
        tick(1);
        chk1("pwr_chg_single", o_mode_chg, 1'b0);

        i_adc1_req = 1'b1; i_normal_req = 1'b1; tick(1); i_normal_req = 1'b0;
        chk8("normal_adc1", o_reg_mode, 8'hA2);
        i_fsiso_trig = 1'b1; i_cfg_req = 1'b1; i_adc1_req = 1'b0; tick(1); i_cfg_req = 1'b0;
        chk8("fsiso_wins", o_reg_mode, 8'h90);
        i_fsiso_clr = 1'b1; tick(1);
        chk8("fsiso_blocked", o_reg_mode, 8'h90);
        i_fsiso_trig = 1'b0; tick(1); i_fsiso_clr = 1'b0;
        chk8("fsiso_exit", o_reg_mode, 8'h84);

        i_bist_req = 1'b1; tick(1); i_bist_req = 1'b0;
        chk8("bist_entry", o_reg_mode, 8'h88);
        i_bist_done = 1'b1; tick(1); i_bist_done = 1'b0;
        chk8("bist_done", o_reg_mode, 8'h84);
        i_bist_req = 1'b1; tick(1); i_bist_req = 1'b0;
        tick(31);
        chk8("bist_before_tmo", o_reg_mode, 8'h88);
        chk1("bist_err_before", o_bist_err, 1'b0);
        tick(1);
        chk8("bist_tmo_mode", o_reg_mode, 8'h90);
        chk1("bist_err_set", o_bist_err, 1'b1);

        i_fsiso_clr = 1'b1; tick(1); i_fsiso_clr = 1'b0;
        i_normal_req = 1'b1; tick(1); i_normal_req = 1'b0;
        chk8("normal_plain", o_reg_mode, 8'h82);
        i_reset_req = 1'b1; tick(1); i_reset_req = 1'b0;
        chk8("soft_rst_mode", o_reg_mode, 8'h01);
        chk1("soft_rst_lreq", o_efuse_load_req, 1'b1);
        chk1("soft_rst_berr_kept", o_bist_err, 1'b1);
        tick(15);
        chk8("efuse_before_tmo", o_reg_mode, 8'h01);
        tick(1);
        chk8("efuse_tmo_mode", o_reg_mode, 8'h10);
        chk1("efuse_err_set", o_efuse_err, 1'b1);
        i_fsiso_clr = 1'b1; tick(1); i_fsiso_clr = 1'b0;
        chk8("cfg_no_efuse", o_reg_mode, 8'h04);
        i_bist_req = 1'b1; tick(1); i_bist_req = 1'b0;
        chk8("bist_no_efuse", o_reg_mode, 8'h08);
        rst = 1'b1; tick(1);
        chk8("hard_rst_mode", o_reg_mode, 8'h01);
        chk1("hard_rst_eerr", o_efuse_err, 1'b0);
        chk1("hard_rst_berr", o_bist_err, 1'b0);
        rst = 1'b0;

        for (int i = 0; i < 4000; i++) begin
            rst               = pct(1) & ($urandom_range(0, 3) == 0);
            i_efuse_load_done = pct(5);
            i_bist_done       = pct(4);
            i_reset_req       = pct(2);
            i_fsiso_trig      = pct(6);
            i_fsiso_clr       = pct(25);
            i_bist_req        = pct(10);
            i_cfg_req         = pct(10);
            i_normal_req      = pct(15);
            i_adc1_req        = pct(50);
            i_adc2_req        = pct(50);
            tick(1);
        end
        clear_inputs();
        rst = 1'b0;
        tick(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
